// File: rtl/isp_session_ctrl_pkg.sv
// isp_session_ctrl_pkg: shared constants, FSM states and frame helpers for the ISP loader.
package isp_session_ctrl_pkg;
   localparam logic [7:0] SYNC0_DEF = 8'hA5;
   localparam logic [7:0] SYNC1_DEF = 8'h5A;
   localparam int         LEN_W     = 16;

   // Frame: SYNC0 SYNC1 LEN_LO LEN_HI payload(LE words) CSUM
   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   function automatic logic len_too_big(input logic [LEN_W-1:0] len, input int aw);
      return 32'(len) > (32'd1 << aw);
   endfunction
endpackage

// File: rtl/isp_session_ctrl_byte_packer.sv
// isp_byte_packer: assembles little-endian 32-bit words from a byte stream,
// flagging the fourth byte of each word combinationally.
module isp_byte_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        ready_o
);
   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] buf_q, buf_d;

   always_comb begin
      cnt_d = clr_i ? 2'd0 : valid_i ? cnt_q + 2'd1 : cnt_q;
      buf_d = buf_q;
      if (valid_i && cnt_q != 2'd3)
         buf_d = cnt_q == 2'd0 ? {buf_q[23:8], byte_i} :
                 cnt_q == 2'd1 ? {buf_q[23:16], byte_i, buf_q[7:0]} :
                                 {byte_i, buf_q[15:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 2'd0;
         buf_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         buf_q <= buf_d;
      end
   end

   // The last byte bypasses the buffer so the word is complete on its strobe.
   assign word_o  = {byte_i, buf_q};
   assign ready_o = valid_i && cnt_q == 2'd3;
endmodule

// File: rtl/isp_session_ctrl.sv
// isp_session_ctrl: UART-framed ISP loader for the core's instruction RAM; holds the
// core in reset during a session and owns the RAM write port while holding.
module isp_session_ctrl
   import isp_session_ctrl_pkg::*;
#(
   parameter int         AW          = 14,
   parameter int         TIMEOUT_CYC = 1000000,
   parameter logic [7:0] SYNC0       = SYNC0_DEF,
   parameter logic [7:0] SYNC1       = SYNC1_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [31:0]   cpu_wdata,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_wdata,
   output logic          cpu_hold,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   words_written
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d, len_new;
   logic [7:0]         csum_q, csum_d;
   logic [AW:0]        ww_q, ww_d;
   logic               hold_q, hold_d, err_q, err_d;
   logic               ld_we_q, ld_we_d;
   logic [AW-1:0]      ld_addr_q, ld_addr_d;
   logic [31:0]        ld_data_q, ld_data_d;
   logic [TW-1:0]      tmo_q, tmo_d;
   logic               active, tmo_hit, pk_clr, pk_ready;
   logic [31:0]        pk_word;

   isp_byte_packer u_packer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (pk_clr),
      .valid_i (rx_valid && state_q == DATA),
      .byte_i  (rx_data),
      .word_o  (pk_word),
      .ready_o (pk_ready)
   );

   assign active  = state_q inside {LEN0, LEN1, DATA, CSUM};
   assign tmo_hit = active && !rx_valid && tmo_q == TW'(TIMEOUT_CYC - 1);
   assign len_new = {rx_data, len_q[7:0]};

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      csum_d    = csum_q;
      ww_d      = ww_q;
      hold_d    = hold_q;
      err_d     = err_q;
      ld_we_d   = 1'b0;
      ld_addr_d = ld_addr_q;
      ld_data_d = ld_data_q;
      pk_clr    = 1'b0;
      tmo_d     = active && !rx_valid ? tmo_q + 1'b1 : '0;
      case (state_q)
         IDLE: if (rx_valid && rx_data == SYNC0) state_d = SYNC;
         SYNC: if (rx_valid) begin
            if (rx_data == SYNC1) begin
               state_d = LEN0;
               hold_d  = 1'b1;
               err_d   = 1'b0;
               ww_d    = '0;
               csum_d  = '0;
               pk_clr  = 1'b1;
            end else if (rx_data != SYNC0) begin
               state_d = IDLE;
            end
         end
         LEN0: if (rx_valid) begin
            len_d[7:0] = rx_data;
            state_d    = LEN1;
         end
         LEN1: if (rx_valid) begin
            len_d   = len_new;
            state_d = len_too_big(len_new, AW) ? ERR : len_new == '0 ? CSUM : DATA;
         end
         DATA: if (rx_valid) begin
            csum_d = csum_q + rx_data;
            // Write is registered: the RAM sees it the cycle after the 4th byte.
            if (pk_ready) begin
               ld_we_d   = 1'b1;
               ld_addr_d = ww_q[AW-1:0];
               ld_data_d = pk_word;
               ww_d      = ww_q + 1'b1;
               if (32'(ww_q) + 32'd1 == 32'(len_q)) state_d = CSUM;
            end
         end
         CSUM: if (rx_valid) state_d = rx_data == csum_q ? DONE : ERR;
         DONE: begin
            hold_d  = 1'b0;
            state_d = IDLE;
         end
         ERR: begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (tmo_hit) state_d = ERR;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         csum_q    <= '0;
         ww_q      <= '0;
         hold_q    <= 1'b0;
         err_q     <= 1'b0;
         ld_we_q   <= 1'b0;
         ld_addr_q <= '0;
         ld_data_q <= '0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         csum_q    <= csum_d;
         ww_q      <= ww_d;
         hold_q    <= hold_d;
         err_q     <= err_d;
         ld_we_q   <= ld_we_d;
         ld_addr_q <= ld_addr_d;
         ld_data_q <= ld_data_d;
         tmo_q     <= tmo_d;
      end
   end

   assign ram_we        = hold_q ? ld_we_q : cpu_we;
   assign ram_addr      = hold_q ? ld_addr_q : cpu_addr;
   assign ram_wdata     = hold_q ? ld_data_q : cpu_wdata;
   assign cpu_hold      = hold_q;
   assign busy          = !(state_q inside {IDLE, SYNC});
   assign done          = state_q == DONE;
   assign err           = err_q;
   assign words_written = ww_q;
endmodule
